// File: rtl/xcom_link_rx.sv
// xcom_link_rx: XCOM two-wire link receiver (sync, per-edge bit sampling, header/payload decode)
module xcom_link_rx #(
    parameter int TOUT_CYC = 255
) (
    input  logic        x_clk_i,
    input  logic        x_rst_i,
    input  logic        rx_dt_i,
    input  logic        rx_ck_i,
    output logic        rx_vld_o,
    output logic [7:0]  rx_header_o,
    output logic [31:0] rx_data_o,
    output logic        rx_err_o,
    output logic        rx_busy_o
);
    localparam logic [2:0] RX_IDLE = 3'd0;
    localparam logic [2:0] RX_HDR  = 3'd1;
    localparam logic [2:0] RX_DATA = 3'd2;
    localparam logic [2:0] RX_END  = 3'd3;
    localparam logic [2:0] RX_ERR  = 3'd4;

    logic [2:0]  ck_q, ck_d;
    logic [1:0]  dt_q, dt_d;
    logic [2:0]  state_q, state_d;
    logic [39:0] sh_q, sh_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tout_q, tout_d;
    logic [1:0]  len_q, len_d;
    logic        vld_q, vld_d, err_q, err_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [31:0] data_q, data_d;
    logic        edge_s;
    logic [5:0]  len_bits;

    // ck_q = {delayed, 2nd stage, 1st stage}; dt_q[1] is aligned with ck_q[1]
    assign edge_s   = ck_q[1] ^ ck_q[2];
    assign len_bits = (len_q == 2'd3) ? 6'd40 : {1'b0, len_q, 3'b000} + 6'd8;

    always_comb begin
        ck_d      = {ck_q[1:0], rx_ck_i};
        dt_d      = {dt_q[0], rx_dt_i};
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        tout_d    = tout_q;
        len_d     = len_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        vld_d     = state_q == RX_END;
        err_d     = state_q == RX_ERR;
        if (state_q == RX_IDLE) begin
            if (edge_s) begin
                sh_d      = {sh_q[38:0], dt_q[1]};
                bit_cnt_d = 6'd1;
                tout_d    = 8'd0;
                state_d   = RX_HDR;
            end
        end else if (state_q == RX_HDR || state_q == RX_DATA) begin
            if (edge_s) begin
                sh_d      = {sh_q[38:0], dt_q[1]};
                bit_cnt_d = bit_cnt_q + 6'd1;
                tout_d    = 8'd0;
                if (state_q == RX_HDR && bit_cnt_d == 6'd8) begin
                    len_d   = sh_d[6:5];
                    state_d = (sh_d[6:5] == 2'd0) ? RX_END : RX_DATA;
                end else if (state_q == RX_DATA && bit_cnt_d == len_bits) begin
                    state_d = RX_END;
                end
            end else if (tout_q == 8'(TOUT_CYC - 1)) begin
                state_d = RX_ERR;
            end else begin
                tout_d = tout_q + 8'd1;
            end
        end else if (state_q == RX_END) begin
            hdr_d   = (len_q == 2'd0) ? sh_q[7:0]   :
                      (len_q == 2'd1) ? sh_q[15:8]  :
                      (len_q == 2'd2) ? sh_q[23:16] : sh_q[39:32];
            data_d  = (len_q == 2'd0) ? 32'd0                 :
                      (len_q == 2'd1) ? {24'd0, sh_q[7:0]}    :
                      (len_q == 2'd2) ? {16'd0, sh_q[15:0]}   : sh_q[31:0];
            state_d = RX_IDLE;
        end else begin
            state_d = RX_IDLE;
        end
    end

    always_ff @(posedge x_clk_i) begin
        if (x_rst_i) begin
            ck_q      <= '0;
            dt_q      <= '0;
            state_q   <= RX_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            tout_q    <= '0;
            len_q     <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            hdr_q     <= '0;
            data_q    <= '0;
        end else begin
            ck_q      <= ck_d;
            dt_q      <= dt_d;
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            tout_q    <= tout_d;
            len_q     <= len_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
        end
    end

    assign rx_vld_o    = vld_q;
    assign rx_err_o    = err_q;
    assign rx_header_o = hdr_q;
    assign rx_data_o   = data_q;
    assign rx_busy_o   = state_q != RX_IDLE;
endmodule

// File: tb/tb_xcom_link_rx.sv
// tb_xcom_link_rx: randomized packet stimulus checked against a queue-based packet model
module tb_xcom_link_rx;
    localparam int TOUT = 255;
    localparam int NRAND = 500;

    logic        clk = 1'b0;
    logic        x_rst_i, rx_dt_i, rx_ck_i;
    logic        rx_vld_o, rx_err_o, rx_busy_o;
    logic [7:0]  rx_header_o;
    logic [31:0] rx_data_o;

    int          n_tests = 0, n_fail = 0;
    int          vld_seen = 0, err_seen = 0;
    longint      t_last = 0;
    logic [39:0] exp_q[$];
    logic [39:0] e;

    xcom_link_rx #(.TOUT_CYC(TOUT)) dut (
        .x_clk_i(clk), .x_rst_i(x_rst_i), .rx_dt_i(rx_dt_i), .rx_ck_i(rx_ck_i),
        .rx_vld_o(rx_vld_o), .rx_header_o(rx_header_o), .rx_data_o(rx_data_o),
        .rx_err_o(rx_err_o), .rx_busy_o(rx_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sends a packet MSB first; stop > 0 truncates it (no packet expected then)
    task automatic send(input logic [7:0] hdr, input logic [31:0] pay, input int stop,
                        input int gap, input int hmin, input int hmax);
        int nb, n;
        logic [31:0] pm;
        nb = 8 * (int'(hdr[6:5]) + 1) + ((hdr[6:5] == 2'd3) ? 8 : 0);
        pm = (nb == 8) ? 32'd0 : (32'hFFFF_FFFF >> (40 - nb));
        n  = (stop > 0) ? stop : nb;
        if (stop == 0) exp_q.push_back({hdr, pay & pm});
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_dt_i = (i < 8) ? hdr[7 - i] : pay[nb - 1 - i];
            rx_ck_i = ~rx_ck_i;
            if (i == n - 1) t_last = longint'($time) - 1;
            else repeat ($urandom_range(hmax, hmin) - 1) @(posedge clk);
        end
        repeat (gap - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!x_rst_i) begin
            if (rx_err_o) err_seen++;
            if (rx_vld_o) begin
                vld_seen++;
                if (exp_q.size() == 0) check("unexpected_vld", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("header", rx_header_o, e[39:32]);
                    check("data", rx_data_o, e[31:0]);
                    check("vld_latency", (longint'($time) - t_last - 5) / 10, 4);
                end
            end
        end
    end

    initial begin
        bit found;
        int e0, v0;
        x_rst_i = 1'b1; rx_dt_i = 1'b0; rx_ck_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", rx_vld_o, 0);
        check("rst_err", rx_err_o, 0);
        check("rst_busy", rx_busy_o, 0);
        check("rst_hdr", rx_header_o, 0);
        check("rst_data", rx_data_o, 0);
        @(posedge clk); #1 x_rst_i = 1'b0;

        send(8'h00, 32'h0, 0, 3, 4, 4);
        repeat (8) @(posedge clk);
        check("t1_vld_count", vld_seen, 1);

        send(8'h20, 32'h0000_00A5, 0, 3, 3, 3);
        send(8'h40, 32'h0000_BEEF, 0, 3, 2, 4);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_data_hold", rx_data_o, 32'h0000_BEEF);
        check("t2_hdr_hold", rx_header_o, 8'h40);

        send(8'h60, 32'hDEAD_BEEF, 0, 3, 2, 3);
        send(8'h7F, 32'h1234_5678, 0, 3, 2, 3);
        repeat (8) @(posedge clk);
        check("t3_vld_count", vld_seen, 5);

        v0 = vld_seen;
        send(8'h60, 32'hCAFE_F00D, 20, 1, 2, 2);
        found = 1'b0;
        for (int i = 0; i < TOUT + 40 && !found; i++) begin
            @(negedge clk);
            if (rx_err_o) begin
                found = 1'b1;
                check("t4_err_latency", (longint'($time) - t_last - 5) / 10, TOUT + 4);
            end
        end
        check("t4_err_seen", found, 1);
        check("t4_no_vld", vld_seen, v0);
        repeat (3) @(posedge clk);
        send(8'h40, 32'h0000_ABCD, 0, 3, 2, 5);
        repeat (8) @(posedge clk);
        check("t4_recover", vld_seen, v0 + 1);

        send(8'h60, 32'h0, 5, 1, 3, 3);
        @(posedge clk); #1 x_rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_rst_vld", rx_vld_o, 0);
        check("t5_rst_err", rx_err_o, 0);
        check("t5_rst_busy", rx_busy_o, 0);
        check("t5_rst_hdr", rx_header_o, 0);
        check("t5_rst_data", rx_data_o, 0);
        e0 = err_seen;
        @(posedge clk); #1 x_rst_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (rx_busy_o) found = 1'b1;
        end
        check("t5_busy", found, 1);
        repeat (TOUT + 10) @(posedge clk);
        check("t5_err", err_seen, e0 + 1);
        @(negedge clk);
        check("t5_idle", rx_busy_o, 0);
        @(posedge clk); #1 x_rst_i = 1'b1; rx_ck_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 x_rst_i = 1'b0;

        for (int p = 0; p < NRAND; p++)
            send(8'($urandom), $urandom, 0, $urandom_range(6, 3), 2, 8);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("pending_packets", exp_q.size(), 0);
        check("total_vld", vld_seen, 6 + NRAND);
        check("total_err", err_seen, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
